multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 The ports SHALL be as follows:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  IR load
- MemtoReg  out  1  write-back select: 1 = MDR
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- RegWrite  out  1  register file write
- RegDst  out  1  1 = rd, 0 = rt
- illegal_op  out  1  unsupported opcode pulse
- state  out  4  current state encoding, for debug
REQ-003 Supported opcodes SHALL be: 0 (R-type), 35 (lw), 43 (sw), 4 (beq), 2 (j).

Function
REQ-004 The block SHALL be a Moore FSM with a registered state; each output SHALL be a function of state only, except where REQ-006 gates an output with mem_ready.
REQ-005 The state encoding SHALL be: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6, RWB = 7, BEQ = 8, JUMP = 9.
REQ-006 FETCH outputs SHALL be: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00, and IRWrite = PCWrite = mem_ready.
REQ-007 FETCH transitions SHALL be: mem_ready = 1 -> DECODE; otherwise stay in FETCH.
REQ-008 DECODE outputs SHALL be ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00.
REQ-009 DECODE transitions SHALL be: 35 or 43 -> MEMADR; 0 -> EXEC; 4 -> BEQ; 2 -> JUMP; any other opcode -> FETCH with illegal_op = 1 for this cycle only.
REQ-010 MEMADR outputs SHALL be ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00; next state SHALL be MEMRD for opcode 35 and MEMWR for opcode 43.
REQ-011 MEMRD outputs SHALL be MemRead = 1, IorD = 1; the FSM SHALL stay in MEMRD until mem_ready = 1, then go to MEMWB.
REQ-012 MEMWB outputs SHALL be RegWrite = 1, MemtoReg = 1, RegDst = 0; next state SHALL be FETCH.
REQ-013 MEMWR outputs SHALL be MemWrite = 1, IorD = 1; the FSM SHALL stay in MEMWR until mem_ready = 1, then go to FETCH.
REQ-014 EXEC outputs SHALL be ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10; next state SHALL be RWB.
REQ-015 RWB outputs SHALL be RegWrite = 1, RegDst = 1, MemtoReg = 0; next state SHALL be FETCH.
REQ-016 BEQ outputs SHALL be ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01; next state SHALL be FETCH.
REQ-017 JUMP outputs SHALL be PCWrite = 1, PCSource = 10; next state SHALL be FETCH.
REQ-018 Any output not listed for a state SHALL be 0 in that state.
REQ-019 An unused state code (10-15) SHALL cause a transition to FETCH on the next edge, with all outputs 0 while in that code.
REQ-020 At most one of MemRead, MemWrite SHALL be 1 in any cycle.
REQ-021 Write strobes (PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite) SHALL be 1 for exactly one cycle per instruction, except memory stall cycles, where MemWrite holds until mem_ready.
REQ-022 Opcode changes outside DECODE and MEMADR SHALL have no effect on the state sequence.
REQ-023 Instruction latency with no stalls SHALL be: lw 5 cycles; sw 4; R-type 4; beq 3; j 3.
REQ-024 Each stall cycle (mem_ready = 0) in FETCH, MEMRD or MEMWR SHALL add exactly one cycle.

Reset
REQ-025 rst_n = 0 SHALL force state to FETCH immediately, without waiting for a clock edge, and illegal_op to 0.
REQ-026 While rst_n = 0, the outputs SHALL be the FETCH outputs with IRWrite = PCWrite = 0, regardless of mem_ready.
REQ-027 Reset asserted mid-instruction SHALL abandon the instruction, with no further write strobes.
REQ-028 The first active clock edge after rst_n rises SHALL evaluate the FETCH transition.

Verification
REQ-029 The bench SHALL cover these scenarios:
- lw (opcode 35), mem_ready = 1 always -> state sequence 0,1,2,3,4,0; RegWrite = 1 only in state 4, with MemtoReg = 1 and RegDst = 0.
- sw (opcode 43), mem_ready low for 3 cycles in MEMWR -> MemWrite = 1 for 4 consecutive cycles, then FETCH; RegWrite stays 0 throughout.
- R-type (opcode 0) followed by beq (opcode 4) -> states 0,1,6,7,0,1,8,0; ALUOp = 10 in EXEC and 01 in BEQ; PCWriteCond = 1 only in BEQ.
- j (opcode 2) -> states 0,1,9,0; PCWrite = 1 with PCSource = 10 in JUMP.
- Opcode 8 presented in DECODE -> illegal_op = 1 for 1 cycle, then state = 0, with no RegWrite, MemWrite or PCWriteCond.
- rst_n pulled low in MEMRD between clock edges -> state = 0 immediately, all strobes 0, IRWrite = 0 while reset is held; normal fetch resumes after release.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: Moore outputs decoded from the registered state.
// Instruction latency 3-5 cycles plus one per mem_ready=0 cycle in FETCH/MEMRD/MEMWR.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BEQ    = 4'd8,
        JUMP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_J     = 6'd2;

    state_t state_q;
    state_t state_d;
    logic   illegal_q;
    logic   illegal_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d     = FETCH;
        illegal_d   = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // Strobes are qualified by rst_n so a held reset never loads IR/PC.
                IRWrite = mem_ready & rst_n;
                PCWrite = mem_ready & rst_n;
                state_d = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BEQ;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (opcode == OP_LW)
                    state_d = MEMRD;
                else if (opcode == OP_SW)
                    state_d = MEMWR;
                else
                    state_d = FETCH;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = RWB;
            end
            RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BEQ: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            default: state_d = FETCH;
        endcase
    end

    assign illegal_op = illegal_q;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction stream against an instruction-level expected-cycle model, plus literal sequences.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic       ALUSrcA, RegWrite, RegDst, illegal_op;
    logic [3:0] state;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .RegDst(RegDst), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_RWB = 4'd7,
                           S_BEQ = 4'd8, S_JUMP = 4'd9;
    localparam logic [5:0] OP_R = 6'd0, OP_LW = 6'd35, OP_SW = 6'd43, OP_BEQ = 6'd4, OP_J = 6'd2;

    typedef struct packed {
        logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg;
        logic [1:0] pc_source, alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write, reg_dst, illegal;
    } outs_t;

    typedef struct {
        logic [3:0] st;
        logic       mr;
        logic [5:0] op;
        logic       ill;
    } cyc_t;

    cyc_t        q[$];
    logic        pend_ill = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] obs_st = '0;
    logic [15:0] obs_rw = '0, obs_mw = '0, obs_pwc = '0, obs_pw = '0, obs_ill = '0;

    // Per-state output table, as listed for each state of the controller.
    function automatic outs_t expect_outs(logic [3:0] st, logic mr, logic ill, logic in_rst);
        outs_t o;
        o = '0;
        case (st)
            S_FETCH: begin
                o.mem_read = 1'b1; o.alu_src_b = 2'b01;
                o.ir_write = mr & ~in_rst; o.pc_write = mr & ~in_rst;
            end
            S_DECODE: o.alu_src_b = 2'b11;
            S_MEMADR: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            S_MEMRD:  begin o.mem_read = 1'b1; o.iord = 1'b1; end
            S_MEMWB:  begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
            S_MEMWR:  begin o.mem_write = 1'b1; o.iord = 1'b1; end
            S_EXEC:   begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
            S_RWB:    begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
            S_BEQ: begin
                o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_write_cond = 1'b1; o.pc_source = 2'b01;
            end
            S_JUMP:   begin o.pc_write = 1'b1; o.pc_source = 2'b10; end
            default:  o = '0;
        endcase
        o.illegal = ill;
        return o;
    endfunction

    function automatic outs_t dut_outs();
        outs_t o;
        o = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, illegal_op};
        return o;
    endfunction

    function automatic logic [5:0] rnd_op();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(logic [3:0] st, logic mr, logic [5:0] op);
        cyc_t c;
        c.st = st; c.mr = mr; c.op = op; c.ill = 1'b0;
        if (st == S_FETCH && pend_ill) begin
            c.ill = 1'b1;
            pend_ill = 1'b0;
        end
        q.push_back(c);
    endtask

    // Expands one instruction into its expected cycles; opcode is only meaningful in DECODE/MEMADR.
    task automatic gen_instr(logic [5:0] op, int f_stall, int m_stall);
        for (int i = 0; i < f_stall; i++) push(S_FETCH, 1'b0, rnd_op());
        push(S_FETCH, 1'b1, rnd_op());
        push(S_DECODE, rnd_bit(), op);
        case (op)
            OP_LW: begin
                push(S_MEMADR, rnd_bit(), op);
                for (int i = 0; i < m_stall; i++) push(S_MEMRD, 1'b0, rnd_op());
                push(S_MEMRD, 1'b1, rnd_op());
                push(S_MEMWB, rnd_bit(), rnd_op());
            end
            OP_SW: begin
                push(S_MEMADR, rnd_bit(), op);
                for (int i = 0; i < m_stall; i++) push(S_MEMWR, 1'b0, rnd_op());
                push(S_MEMWR, 1'b1, rnd_op());
            end
            OP_R: begin
                push(S_EXEC, rnd_bit(), rnd_op());
                push(S_RWB, rnd_bit(), rnd_op());
            end
            OP_BEQ:  push(S_BEQ, rnd_bit(), rnd_op());
            OP_J:    push(S_JUMP, rnd_bit(), rnd_op());
            default: pend_ill = 1'b1;
        endcase
    endtask

    task automatic check_now(string name, logic [3:0] est, outs_t eo);
        outs_t got;
        got = dut_outs();
        checks++;
        if (state !== est || got !== eo) begin
            errors++;
            $display("FAIL %s t=%0t: state %0d outs %h, expected state %0d outs %h",
                     name, $time, state, got, est, eo);
        end
    endtask

    task automatic check_lit(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Drives each expected cycle's inputs mid-cycle, compares on the falling edge.
    task automatic run_queue(int n);
        cyc_t c;
        while (n > 0 && q.size() > 0) begin
            c = q.pop_front();
            opcode    = c.op;
            mem_ready = c.mr;
            @(negedge clk);
            check_now("cycle", c.st, expect_outs(c.st, c.mr, c.ill, 1'b0));
            obs_st  = {obs_st[59:0], state};
            obs_rw  = {obs_rw[14:0], RegWrite};
            obs_mw  = {obs_mw[14:0], MemWrite};
            obs_pwc = {obs_pwc[14:0], PCWriteCond};
            obs_pw  = {obs_pw[14:0], PCWrite};
            obs_ill = {obs_ill[14:0], illegal_op};
            @(posedge clk);
            #1;
            n--;
        end
    endtask

    initial begin
        logic [5:0] op;
        #2;
        check_now("reset_state", S_FETCH, expect_outs(S_FETCH, 1'b1, 1'b0, 1'b1));
        @(posedge clk); #1;
        check_now("reset_held", S_FETCH, expect_outs(S_FETCH, 1'b1, 1'b0, 1'b1));
        @(posedge clk); #1;
        rst_n = 1'b1;

        gen_instr(OP_LW, 0, 0); push(S_FETCH, 1'b0, rnd_op());
        run_queue(1000);
        check_lit("lw_states", 64'(obs_st[23:0]), 64'h012340);
        check_lit("lw_regwrite", 64'(obs_rw[5:0]), 64'b000010);

        gen_instr(OP_SW, 0, 3); push(S_FETCH, 1'b0, rnd_op());
        run_queue(1000);
        check_lit("sw_states", 64'(obs_st[31:0]), 64'h01255550);
        check_lit("sw_memwrite", 64'(obs_mw[7:0]), 64'b00011110);
        check_lit("sw_regwrite", 64'(obs_rw[7:0]), 64'd0);

        gen_instr(OP_R, 0, 0); gen_instr(OP_BEQ, 0, 0); push(S_FETCH, 1'b0, rnd_op());
        run_queue(1000);
        check_lit("r_beq_states", 64'(obs_st[31:0]), 64'h01670180);
        check_lit("beq_pcwritecond", 64'(obs_pwc[7:0]), 64'b00000010);

        gen_instr(OP_J, 0, 0); push(S_FETCH, 1'b0, rnd_op());
        run_queue(1000);
        check_lit("j_states", 64'(obs_st[15:0]), 64'h0190);
        check_lit("j_pcwrite", 64'(obs_pw[3:0]), 64'b1010);

        gen_instr(6'd8, 0, 0); push(S_FETCH, 1'b0, rnd_op());
        run_queue(1000);
        check_lit("ill_states", 64'(obs_st[11:0]), 64'h010);
        check_lit("ill_pulse", 64'(obs_ill[2:0]), 64'b001);
        check_lit("ill_strobes", 64'({obs_rw[2:0], obs_mw[2:0], obs_pwc[2:0]}), 64'd0);

        // Asynchronous reset while stalled in MEMRD.
        gen_instr(OP_LW, 0, 5);
        run_queue(4);
        check_lit("pre_reset_memrd", 64'(state), 64'd3);
        mem_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_now("async_reset", S_FETCH, expect_outs(S_FETCH, 1'b1, 1'b0, 1'b1));
        repeat (3) begin
            @(negedge clk);
            check_now("reset_hold", S_FETCH, expect_outs(S_FETCH, 1'b1, 1'b0, 1'b1));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete();
        pend_ill = 1'b0;
        gen_instr(OP_J, 1, 0);
        gen_instr(OP_LW, 0, 0);
        run_queue(1000);

        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 5))
                0: op = OP_R;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_BEQ;
                4: op = OP_J;
                default: begin
                    op = rnd_op();
                    if (op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J)
                        op = 6'd8;
                end
            endcase
            gen_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
            run_queue(1000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
